mem_bus_arbiter: RTL

//  Shared-bus controller between NUM_REQ cache controllers and the single-port main memory.

---
 rtl/snoop_bus_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snoop bus: FSM state codes, default bus widths,
// the snoop op encoding and the round-robin pointer advance.
package snoop_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_GRANT  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  localparam logic SNOOP_RD = 1'b0;
  localparam logic SNOOP_WR = 1'b1;

  // Next owner to be favoured once requester idx has been served.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit searching upward
// from rr_ptr_i, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_req_o
);

  int cand;

  always_comb begin
    idx_o     = '0;
    any_req_o = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_i) + k) % NUM_REQ;
      if (!any_req_o && req_i[cand]) begin
        any_req_o = 1'b1;
        idx_o     = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shared-bus controller: round-robin arbitration between cache controllers,
// snoop broadcast of the winning op, and sequencing of the single memory port.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  ST_IDLE   | waiting for a request; arbitrate and latch the operands
//  ST_GRANT  | owner granted, op broadcast on the snoop bus for 1 cycle
//  ST_ACCESS | memory port driven for MEM_LAT cycles, strobe in the last
//  ST_DONE   | ack pulse to owner, round-robin pointer advanced
module mem_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      snoop_valid_o,
  output logic                      snoop_we_o,
  output logic [ADDR_W-1:0]         snoop_addr_o,
  output logic [IDX_W-1:0]          snoop_src_o,
  output logic                      busy_o,
  output logic                      mem_writeEn_o,
  output logic [ADDR_W-1:0]         mem_tagIn_o,
  output logic [DATA_W-1:0]         mem_dataIn_o,
  input  logic [DATA_W-1:0]         mem_dataOut_i
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic                last_access;
  logic [NUM_REQ-1:0]  owner_oh;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_i     (req_i),
    .rr_ptr_i  (rr_ptr_q),
    .idx_o     (win_idx),
    .any_req_o (win_any)
  );

  assign last_access = (cnt_q == CNT_W'(MEM_LAT - 1));
  assign owner_oh    = NUM_REQ'(1) << idx_q;
  assign rdata_o     = rdata_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        // Operands are captured here only; later changes by the requester are ignored.
        if (win_any) begin
          idx_d   = win_idx;
          we_d    = req_we_i[win_idx];
          addr_d  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (last_access) begin
          if (we_q == SNOOP_RD) begin
            rdata_d = mem_dataOut_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rr_ptr_d = IDX_W'(rr_next(int'(idx_q), NUM_REQ));
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o         = '0;
    ack_o         = '0;
    snoop_valid_o = 1'b0;
    snoop_we_o    = 1'b0;
    snoop_addr_o  = '0;
    snoop_src_o   = '0;
    busy_o        = (state_q != ST_IDLE);
    mem_writeEn_o = 1'b0;
    mem_tagIn_o   = '0;
    mem_dataIn_o  = '0;
    unique case (state_q)
      ST_GRANT: begin
        gnt_o         = owner_oh;
        snoop_valid_o = 1'b1;
        snoop_we_o    = (we_q == SNOOP_WR);
        snoop_addr_o  = addr_q;
        snoop_src_o   = idx_q;
      end
      ST_ACCESS: begin
        // Single write strobe in the final access cycle, after the address has settled.
        gnt_o         = owner_oh;
        mem_tagIn_o   = addr_q;
        mem_dataIn_o  = wdata_q;
        mem_writeEn_o = we_q && last_access;
      end
      ST_DONE: begin
        gnt_o = owner_oh;
        ack_o = owner_oh;
      end
      default: ;
    endcase
  end

endmodule
